// File: rtl/alu_issue_if.sv
//------------------------------------------------------------------------------
// Module   : alu_issue_if
// Purpose  : Decoded ALU instruction handshake into the issue stage.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface alu_issue_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [2:0]       in_rd;
    logic [2:0]       in_rn;
    logic [2:0]       in_rm;
    logic [1:0]       in_shift;
    logic             in_zero_a;
    logic             in_use_imm;
    logic [WIDTH-1:0] in_imm;
    logic             in_wb;
    logic             in_status_en;

    modport master (
        output in_valid, in_op, in_rd, in_rn, in_rm, in_shift,
               in_zero_a, in_use_imm, in_imm, in_wb, in_status_en,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rn, in_rm, in_shift,
               in_zero_a, in_use_imm, in_imm, in_wb, in_status_en,
        output in_ready
    );
endinterface

`default_nettype wire

// File: rtl/alu_issue_stage.sv
//------------------------------------------------------------------------------
// Module   : alu_issue_stage
// Purpose  : READ / EXEC / WB sequencer feeding an external 16-bit ALU.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_issue_stage #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    alu_issue_if.slave            inst,
    output logic      [WIDTH-1:0] alu_ain,
    output logic      [WIDTH-1:0] alu_bin,
    output logic      [1:0]       alu_op,
    input  wire logic [WIDTH-1:0] alu_out,
    input  wire logic [2:0]       alu_z,
    output logic      [WIDTH-1:0] result,
    output logic      [2:0]       status,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rf [NREGS];
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [2:0]       r_status;
    logic             r_ready;
    logic             r_done;

    logic [1:0]       r_op;
    logic [2:0]       r_rd;
    logic [2:0]       r_rn;
    logic [2:0]       r_rm;
    logic [1:0]       r_shift;
    logic             r_zero_a;
    logic             r_use_imm;
    logic [WIDTH-1:0] r_imm;
    logic             r_wb;
    logic             r_status_en;

    logic [WIDTH-1:0] w_rm_val;
    logic [WIDTH-1:0] w_shifted;

    // Single-bit B-path shifter; bypassed entirely for immediates.
    always_comb begin
        w_rm_val  = r_rf[r_rm];
        w_shifted = w_rm_val;
        case (r_shift)
            2'b01:   w_shifted = {w_rm_val[WIDTH-2:0], 1'b0};
            2'b10:   w_shifted = {1'b0, w_rm_val[WIDTH-1:1]};
            2'b11:   w_shifted = {w_rm_val[WIDTH-1], w_rm_val[WIDTH-1:1]};
            default: w_shifted = w_rm_val;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_status    <= '0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_op        <= '0;
            r_rd        <= '0;
            r_rn        <= '0;
            r_rm        <= '0;
            r_shift     <= '0;
            r_zero_a    <= 1'b0;
            r_use_imm   <= 1'b0;
            r_imm       <= '0;
            r_wb        <= 1'b0;
            r_status_en <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (inst.in_valid) begin
                        r_op        <= inst.in_op;
                        r_rd        <= inst.in_rd;
                        r_rn        <= inst.in_rn;
                        r_rm        <= inst.in_rm;
                        r_shift     <= inst.in_shift;
                        r_zero_a    <= inst.in_zero_a;
                        r_use_imm   <= inst.in_use_imm;
                        r_imm       <= inst.in_imm;
                        r_wb        <= inst.in_wb;
                        r_status_en <= inst.in_status_en;
                        r_ready     <= 1'b0;
                        r_state     <= S_READ;
                    end
                end
                S_READ: begin
                    r_a     <= r_zero_a ? '0 : r_rf[r_rn];
                    r_b     <= r_use_imm ? r_imm : w_shifted;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_c <= alu_out;
                    if (r_status_en) begin
                        r_status <= alu_z;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_WB;
                end
                S_WB: begin
                    // Write lands before the next READ can sample the file.
                    if (r_wb) begin
                        r_rf[r_rd] <= r_c;
                    end
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign inst.in_ready = r_ready;
    assign alu_ain       = r_a;
    assign alu_bin       = r_b;
    assign alu_op        = r_op;
    assign result        = r_c;
    assign status        = r_status;
    assign done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_issue_stage
// Purpose  : Scoreboard bench for alu_issue_stage with a behavioural ALU.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue_stage;

    logic        clk;
    logic        reset;
    logic [15:0] alu_ain;
    logic [15:0] alu_bin;
    logic [1:0]  alu_op;
    logic [15:0] alu_out;
    logic [2:0]  alu_z;
    logic [15:0] result;
    logic [2:0]  status;
    logic        done;

    alu_issue_if #(.WIDTH(16)) ifc ();

    alu_issue_stage #(.WIDTH(16), .NREGS(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .inst    (ifc.slave),
        .alu_ain (alu_ain),
        .alu_bin (alu_bin),
        .alu_op  (alu_op),
        .alu_out (alu_out),
        .alu_z   (alu_z),
        .result  (result),
        .status  (status),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ALU stand-in, bit-level flag formulation.
    always_comb begin
        logic [15:0] o;
        logic        v;
        case (alu_op)
            2'b00:   o = alu_ain + alu_bin;
            2'b01:   o = alu_ain - alu_bin;
            2'b10:   o = alu_ain & alu_bin;
            default: o = ~alu_bin;
        endcase
        if (alu_op == 2'b00)
            v = (alu_ain[15] == alu_bin[15]) && (o[15] != alu_ain[15]);
        else if (alu_op == 2'b01)
            v = (alu_ain[15] != alu_bin[15]) && (o[15] != alu_ain[15]);
        else
            v = 1'b0;
        alu_out = o;
        alu_z   = {(o == 16'h0000), v, o[15]};
    end

    typedef struct {
        logic [15:0] res;
        logic [2:0]  st;
    } exp_t;

    exp_t        sb[$];
    int          mreg[8];
    logic [2:0]  mstatus;
    int          total = 0;
    int          bad   = 0;
    int          n_issued = 0;
    int          n_done   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_signed(input int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    function automatic int shift_val(input int x, input int sh);
        case (sh)
            1:       return (x * 2) % 65536;
            2:       return x / 2;
            3:       return x / 2 + ((x >= 32768) ? 32768 : 0);
            default: return x;
        endcase
    endfunction

    // Reference: integer arithmetic, V from signed-range overflow.
    task automatic ref_exec(input int op, input int a, input int b, output int res, output logic [2:0] fl);
        int s;
        logic v;
        v = 1'b0;
        case (op)
            0: begin
                res = (a + b) % 65536;
                s   = to_signed(a) + to_signed(b);
                v   = (s > 32767) || (s < -32768);
            end
            1: begin
                res = (a - b + 65536) % 65536;
                s   = to_signed(a) - to_signed(b);
                v   = (s > 32767) || (s < -32768);
            end
            2: res = a & b;
            default: res = 65535 - b;
        endcase
        fl = {(res == 0), v, (res >= 32768)};
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("done_without_issue", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("status", 32'(status), 32'(e.st));
            end
        end
    end

    task automatic drive_idle();
        ifc.in_valid     = 1'b0;
        ifc.in_op        = '0;
        ifc.in_rd        = '0;
        ifc.in_rn        = '0;
        ifc.in_rm        = '0;
        ifc.in_shift     = '0;
        ifc.in_zero_a    = 1'b0;
        ifc.in_use_imm   = 1'b0;
        ifc.in_imm       = '0;
        ifc.in_wb        = 1'b0;
        ifc.in_status_en = 1'b0;
    endtask

    task automatic drive_junk();
        ifc.in_valid     = 1'($urandom_range(0, 1));
        ifc.in_op        = 2'($urandom);
        ifc.in_rd        = 3'($urandom);
        ifc.in_rn        = 3'($urandom);
        ifc.in_rm        = 3'($urandom);
        ifc.in_shift     = 2'($urandom);
        ifc.in_zero_a    = 1'($urandom);
        ifc.in_use_imm   = 1'($urandom);
        ifc.in_imm       = 16'($urandom);
        ifc.in_wb        = 1'($urandom);
        ifc.in_status_en = 1'($urandom);
    endtask

    // Called at a negedge with the DUT idle; returns at the next idle negedge.
    task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rn,
                         input logic [2:0] rm, input logic [1:0] sh, input logic za,
                         input logic ui, input logic [15:0] imm, input logic wb,
                         input logic se, input bit junk);
        int a, b, res;
        logic [2:0] fl;
        exp_t e;
        check("in_ready_idle", 32'(ifc.in_ready), 32'(1));
        ifc.in_valid     = 1'b1;
        ifc.in_op        = op;
        ifc.in_rd        = rd;
        ifc.in_rn        = rn;
        ifc.in_rm        = rm;
        ifc.in_shift     = sh;
        ifc.in_zero_a    = za;
        ifc.in_use_imm   = ui;
        ifc.in_imm       = imm;
        ifc.in_wb        = wb;
        ifc.in_status_en = se;
        a = za ? 0 : mreg[rn];
        b = ui ? int'(imm) : shift_val(mreg[rm], int'(sh));
        ref_exec(int'(op), a, b, res, fl);
        if (se) mstatus = fl;
        if (wb) mreg[rd] = res;
        e.res = 16'(res);
        e.st  = mstatus;
        sb.push_back(e);
        n_issued++;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            check("in_ready_busy", 32'(ifc.in_ready), 32'(0));
            check("done_timing", 32'(done), 32'(cyc == 3));
            if (cyc == 2) begin
                check("alu_ain", 32'(alu_ain), 32'(a));
                check("alu_bin", 32'(alu_bin), 32'(b));
                check("alu_op", 32'(alu_op), 32'(op));
            end
            if (junk) drive_junk();
            else      drive_idle();
        end
        drive_idle();
        @(negedge clk);
    endtask

    task automatic readback(input logic [2:0] r);
        issue(2'b00, 3'd0, 3'd0, r, 2'b00, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) mreg[i] = 0;
        mstatus = 3'b000;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(ifc.in_ready), 32'(1));
        check("rst_done", 32'(done), 32'(0));
        reset = 1'b0;
        @(negedge clk);
        check("rst_result", 32'(result), 32'(0));
        check("rst_status", 32'(status), 32'(0));
        check("rst_ain", 32'(alu_ain), 32'(0));
        check("rst_bin", 32'(alu_bin), 32'(0));
        check("rst_op", 32'(alu_op), 32'(0));

        // MOV R1=5, ADD R2=R1+(R1<<1), read R2, CMP R1,R1
        issue(2'b00, 3'd1, 3'd0, 3'd0, 2'b00, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b1, 1'b0);
        issue(2'b00, 3'd2, 3'd1, 3'd1, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        readback(3'd2);
        issue(2'b01, 3'd0, 3'd1, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        // Overflowing SUB, then AND leaving status untouched
        issue(2'b00, 3'd3, 3'd0, 3'd0, 2'b00, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0);
        issue(2'b00, 3'd4, 3'd0, 3'd0, 2'b00, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b0);
        issue(2'b01, 3'd5, 3'd3, 3'd4, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        issue(2'b10, 3'd6, 3'd3, 3'd4, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        // NOT of asr / lsr of 0x8000
        issue(2'b11, 3'd7, 3'd0, 3'd4, 2'b11, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        issue(2'b11, 3'd7, 3'd0, 3'd4, 2'b10, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        for (int r = 0; r < 8; r++) readback(3'(r));

        for (int n = 0; n < 150; n++) begin
            issue(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 2'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                  16'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
        end
        for (int r = 0; r < 8; r++) readback(3'(r));

        // Reset during EXEC of MOV R6: no write, no done
        issue(2'b00, 3'd6, 3'd0, 3'd0, 2'b00, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        ifc.in_valid   = 1'b1;
        ifc.in_rd      = 3'd6;
        ifc.in_zero_a  = 1'b1;
        ifc.in_use_imm = 1'b1;
        ifc.in_imm     = 16'h1234;
        ifc.in_wb      = 1'b1;
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_in_ready", 32'(ifc.in_ready), 32'(1));
        check("abort_done", 32'(done), 32'(0));
        check("abort_result", 32'(result), 32'(0));
        check("abort_status", 32'(status), 32'(0));
        @(negedge clk);
        check("abort_done_later", 32'(done), 32'(0));
        reset = 1'b0;
        for (int i = 0; i < 8; i++) mreg[i] = 0;
        mstatus = 3'b000;
        @(negedge clk);
        for (int r = 0; r < 8; r++) readback(3'(r));

        for (int n = 0; n < 30; n++) begin
            issue(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 2'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                  16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        for (int r = 0; r < 8; r++) readback(3'(r));

        repeat (6) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'(0));
        check("done_count", 32'(n_done), 32'(n_issued));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
